// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned CNT_W      = 4;

    // Data returned for an out-of-range read when bounds checking is built in.
    localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory request/response bus. bus_err exists only with MEM_BOUNDS_CHECK_EN.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] addr;
    logic              read_mem_req;
    logic              read_mem_valid;
    logic              read_mem_finish;
    logic [DATA_W-1:0] mem_rdata;
    logic              write_mem_req;
    logic [DATA_W-1:0] mem_wdata;
    logic              write_mem_valid;
    logic              write_mem_finish;
`ifdef MEM_BOUNDS_CHECK_EN
    logic              bus_err;
`endif

    modport master (
        output addr, read_mem_req, write_mem_req, mem_wdata,
        input  read_mem_valid, read_mem_finish, mem_rdata,
        input  write_mem_valid, write_mem_finish
`ifdef MEM_BOUNDS_CHECK_EN
        , input bus_err
`endif
    );

    modport slave (
        input  addr, read_mem_req, write_mem_req, mem_wdata,
        output read_mem_valid, read_mem_finish, mem_rdata,
        output write_mem_valid, write_mem_finish
`ifdef MEM_BOUNDS_CHECK_EN
        , output bus_err
`endif
    );

endinterface

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM: write-enable port and registered (read-first) read.
module mem_ram_sp #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata_q
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write on enable; read data registered every cycle from the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding read/write with fixed access latency.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range accesses return BUS_ERR_DATA,
// suppress the write, and pulse bus_err alongside valid.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned DEPTH_LOG2    = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                own_wr_q, own_wr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_valid_q, wr_valid_d;
    logic                rd_fin_q, rd_fin_d;
    logic                wr_fin_q, wr_fin_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef MEM_BOUNDS_CHECK_EN
    logic                bus_err_q, bus_err_d;
`endif

    logic                owner_req_c;
    logic                addr_oob_c;
    logic                ram_we_c;
    logic [DATA_W-1:0]   ram_rdata;

    // Request that owns the current transaction; drives abort and DONE exit.
    assign owner_req_c = own_wr_q ? bus.write_mem_req : bus.read_mem_req;

`ifdef MEM_BOUNDS_CHECK_EN
    // Any upper address bit set means the word lies beyond the RAM.
    assign addr_oob_c = |addr_q[ADDR_W-1:DEPTH_LOG2];
`else
    // Without bounds checking the upper bits alias onto the RAM.
    logic unused_addr_hi;
    assign addr_oob_c     = 1'b0;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:DEPTH_LOG2];
`endif

    // RAM address follows the next latched address so read data is ready before RESP.
    mem_ram_sp #(
        .AW (DEPTH_LOG2),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c & ~rst),
        .addr    (addr_d[DEPTH_LOG2-1:0]),
        .wdata   (wdata_q),
        .rdata_q (ram_rdata)
    );

    // Next-state, latency counter, latches and registered handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        own_wr_d   = own_wr_q;
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        rd_fin_d   = 1'b0;
        wr_fin_d   = 1'b0;
        rdata_d    = rdata_q;
        ram_we_c   = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.write_mem_req) begin
                    addr_d   = bus.addr;
                    wdata_d  = bus.mem_wdata;
                    cnt_d    = CNT_W'(WRITE_LATENCY);
                    own_wr_d = 1'b1;
                    state_d  = ST_WR_WAIT;
                end else if (bus.read_mem_req) begin
                    addr_d   = bus.addr;
                    cnt_d    = CNT_W'(READ_LATENCY);
                    own_wr_d = 1'b0;
                    state_d  = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (!owner_req_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (own_wr_q) begin
                    state_d    = ST_WR_RESP;
                    wr_valid_d = 1'b1;
                    ram_we_c   = ~addr_oob_c;
`ifdef MEM_BOUNDS_CHECK_EN
                    bus_err_d  = addr_oob_c;
`endif
                end else begin
                    state_d    = ST_RD_RESP;
                    rd_valid_d = 1'b1;
                    rdata_d    = addr_oob_c ? DATA_W'(BUS_ERR_DATA) : ram_rdata;
`ifdef MEM_BOUNDS_CHECK_EN
                    bus_err_d  = addr_oob_c;
`endif
                end
            end
            ST_RD_RESP, ST_WR_RESP: begin
                state_d  = ST_DONE;
                rd_fin_d = ~own_wr_q;
                wr_fin_d = own_wr_q;
            end
            ST_DONE: begin
                if (owner_req_c) begin
                    rd_fin_d = ~own_wr_q;
                    wr_fin_d = own_wr_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; RAM contents are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            own_wr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_fin_q   <= 1'b0;
            wr_fin_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            own_wr_q   <= own_wr_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_fin_q   <= rd_fin_d;
            wr_fin_q   <= wr_fin_d;
            rdata_q    <= rdata_d;
`ifdef MEM_BOUNDS_CHECK_EN
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign bus.read_mem_valid   = rd_valid_q;
    assign bus.read_mem_finish  = rd_fin_q;
    assign bus.mem_rdata        = rdata_q;
    assign bus.write_mem_valid  = wr_valid_q;
    assign bus.write_mem_finish = wr_fin_q;
`ifdef MEM_BOUNDS_CHECK_EN
    assign bus.bus_err          = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level expectations scheduled per cycle,
// checked every cycle, plus literal pins. Honours MEM_BOUNDS_CHECK_EN.
module tb_mem_responder;

    localparam int unsigned RL = 2;
    localparam int unsigned WL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_responder #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .DEPTH_LOG2    (8),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Expected outputs keyed by cycle (cycle n = interval after the n-th rising edge).
    bit          e_rv [int];
    bit          e_wv [int];
    bit          e_rf [int];
    bit          e_wf [int];
    bit          e_err[int];
    bit          e_clr[int];
    logic [15:0] e_rdata[int];

    logic [15:0] model_mem [256];
    logic [15:0] model_rdata = 16'h0000;
    int          last_rv_cyc = -1;
    int          last_wv_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Schedule the visible effects of one transaction; idle_at = edge that returns to IDLE.
    task automatic sched(input bit is_wr, input int e0, input int drop,
                         input logic [15:0] a, input logic [15:0] d, output int idle_at);
        int lat;
        int vc;
        int fin_end;
        bit oob;
        lat = is_wr ? int'(WL) : int'(RL);
        vc  = e0 + lat + 1;
        oob = 1'b0;
        if (drop + 1 <= vc) begin
            idle_at = drop + 1;
            return;
        end
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (a >= 16'h0100);
        if (oob) e_err[vc] = 1'b1;
`endif
        if (is_wr) begin
            e_wv[vc] = 1'b1;
            if (!oob) model_mem[a[7:0]] = d;
        end else begin
            e_rv[vc]    = 1'b1;
            e_rdata[vc] = oob ? 16'hDEAD : model_mem[a[7:0]];
        end
        fin_end = (drop > vc + 1) ? drop : vc + 1;
        for (int c = vc + 1; c <= fin_end; c++) begin
            if (is_wr) e_wf[c] = 1'b1;
            else       e_rf[c] = 1'b1;
        end
        idle_at = fin_end + 1;
    endtask

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (e_clr.exists(cyc)) model_rdata = 16'h0000;
            if (e_rv.exists(cyc))  model_rdata = e_rdata[cyc];
            if (bus.read_mem_valid === 1'b1)  last_rv_cyc = cyc;
            if (bus.write_mem_valid === 1'b1) last_wv_cyc = cyc;
            chk("read_mem_valid",   16'(bus.read_mem_valid),   16'(e_rv.exists(cyc)));
            chk("read_mem_finish",  16'(bus.read_mem_finish),  16'(e_rf.exists(cyc)));
            chk("write_mem_valid",  16'(bus.write_mem_valid),  16'(e_wv.exists(cyc)));
            chk("write_mem_finish", 16'(bus.write_mem_finish), 16'(e_wf.exists(cyc)));
            chk("mem_rdata",        bus.mem_rdata,             model_rdata);
`ifdef MEM_BOUNDS_CHECK_EN
            chk("bus_err",          16'(bus.bus_err),          16'(e_err.exists(cyc)));
`endif
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // CPU-side transaction: raise req, scramble addr/data after sampling, drop after hold cycles.
    task automatic txn(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                       input int hold, output int k);
        int idle_at;
        @(posedge clk);
        #1;
        k = cyc;
        bus.addr      = a;
        bus.mem_wdata = d;
        if (is_wr) bus.write_mem_req = 1'b1;
        else       bus.read_mem_req  = 1'b1;
        sched(is_wr, k + 1, k + hold, a, d, idle_at);
        @(posedge clk);
        #1;
        bus.addr      = 16'hFFFF;
        bus.mem_wdata = 16'h0BAD;
        wait_until(k + hold);
        bus.write_mem_req = 1'b0;
        bus.read_mem_req  = 1'b0;
        wait_until(idle_at - 1);
    endtask

    initial begin
        int k;
        int idle_w;
        int idle_r;
        bus.addr          = '0;
        bus.mem_wdata     = '0;
        bus.read_mem_req  = 1'b0;
        bus.write_mem_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata",  bus.mem_rdata, 16'h0000);
        chk("reset_rvalid", 16'(bus.read_mem_valid), 16'h0000);
        rst = 1'b0;

        // Write then read back, with latency pins.
        txn(1'b1, 16'h0005, 16'h1234, 6, k);
        chk("wr_valid_latency", 16'(last_wv_cyc - (k + 1)), 16'd2);
        txn(1'b0, 16'h0005, 16'h0000, 7, k);
        chk("rd_valid_latency", 16'(last_rv_cyc - (k + 1)), 16'd3);
        chk("rd_back_0005", bus.mem_rdata, 16'h1234);

        // Simultaneous read and write: write first, read after write finish drops.
        @(posedge clk);
        #1;
        k = cyc;
        bus.addr          = 16'h0010;
        bus.mem_wdata     = 16'hBEEF;
        bus.write_mem_req = 1'b1;
        bus.read_mem_req  = 1'b1;
        sched(1'b1, k + 1, k + 6, 16'h0010, 16'hBEEF, idle_w);
        sched(1'b0, idle_w + 1, k + 14, 16'h0010, 16'h0000, idle_r);
        @(posedge clk);
        #1;
        bus.addr      = 16'hFFFF;
        bus.mem_wdata = 16'h0BAD;
        wait_until(k + 6);
        bus.write_mem_req = 1'b0;
        bus.addr          = 16'h0010;
        wait_until(k + 14);
        bus.read_mem_req = 1'b0;
        wait_until(idle_r - 1);
        chk("simul_rd_beef", bus.mem_rdata, 16'hBEEF);
        chk("simul_rd_latency", 16'(last_rv_cyc - (k + 8)), 16'd3);

        // Write abort leaves the old value.
        txn(1'b1, 16'h0020, 16'h0001, 6, k);
        txn(1'b1, 16'h0020, 16'hFFFF, 1, k);
        txn(1'b0, 16'h0020, 16'h0000, 6, k);
        chk("abort_keeps_0001", bus.mem_rdata, 16'h0001);

        // Read request dropped in RESP: one-cycle finish.
        txn(1'b0, 16'h0005, 16'h0000, 4, k);

        // Reset in RD_WAIT, then re-issue the read.
        @(posedge clk);
        #1;
        k = cyc;
        bus.addr         = 16'h0020;
        bus.read_mem_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e_clr[k + 3] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.read_mem_req = 1'b0;
        chk("rst_mid_rdata", bus.mem_rdata, 16'h0000);
        chk("rst_mid_rvalid", 16'(bus.read_mem_valid), 16'h0000);
        txn(1'b0, 16'h0005, 16'h0000, 6, k);
        chk("reread_0005", bus.mem_rdata, 16'h1234);

`ifdef MEM_BOUNDS_CHECK_EN
        txn(1'b1, 16'h0000, 16'h0000, 6, k);
        txn(1'b0, 16'h0100, 16'h0000, 6, k);
        chk("oob_read_dead", bus.mem_rdata, 16'hDEAD);
        txn(1'b1, 16'h0100, 16'h7777, 6, k);
        txn(1'b0, 16'h0000, 16'h0000, 6, k);
        chk("oob_write_dropped", bus.mem_rdata, 16'h0000);
`else
        txn(1'b1, 16'h0103, 16'hA5A5, 6, k);
        txn(1'b0, 16'h0003, 16'h0000, 6, k);
        chk("alias_0003", bus.mem_rdata, 16'hA5A5);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
